// File: rtl/preamble_tx_pkg.sv
// Shared definitions for the preamble transmitter and the RX correlator:
// {I16,Q16} sample packing and the TX sequencer state encoding.
package preamble_tx_pkg;

  localparam int unsigned IQ_WIDTH     = 16;
  localparam int unsigned SAMPLE_WIDTH = 2 * IQ_WIDTH;
  // I occupies the upper half of a sample, Q the lower half.
  localparam int unsigned I_LSB        = IQ_WIDTH;
  localparam int unsigned Q_LSB        = 0;

  typedef enum logic [2:0] {
    StIdle,
    StPrefetch,
    StPreamble,
    StPayload,
    StGap
  } state_e;

  function automatic logic [SAMPLE_WIDTH-1:0] pack_iq(input logic [IQ_WIDTH-1:0] i_val,
                                                      input logic [IQ_WIDTH-1:0] q_val);
    return {i_val, q_val};
  endfunction

endpackage

// File: rtl/preamble_tx_if.sv
// Payload stream into the preamble transmitter (valid/ready with end-of-burst marker).
interface preamble_tx_if
  import preamble_tx_pkg::*;
#(
  parameter int unsigned DataWidth = SAMPLE_WIDTH
) ();

  logic [DataWidth-1:0] src_data;
  logic                 src_valid;
  logic                 src_last;
  logic                 src_ready;

  modport master (output src_data, output src_valid, output src_last, input src_ready);
  modport slave  (input src_data, input src_valid, input src_last, output src_ready);

endinterface

// File: rtl/preamble_tbl.sv
// Preamble segment table: one write port, one registered read port (read-before-write).
module preamble_tbl #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [(1 << AW)];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/preamble_tx.sv
// Preamble burst sequencer: repeats a table segment, then streams payload, then a zero gap,
// presenting one registered sample per DUC strobe.
module preamble_tx
  import preamble_tx_pkg::*;
#(
  parameter int unsigned TBL_AW       = 8,
  parameter int unsigned SAMPLE_WIDTH = preamble_tx_pkg::SAMPLE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    duc_in_enable,
  input  logic                    duc_in_strobe,
  output logic [SAMPLE_WIDTH-1:0] duc_in_sample,
  input  logic                    start,
  input  logic [TBL_AW-1:0]       seg_len,
  input  logic [3:0]              num_reps,
  input  logic [7:0]              gap_len,
  input  logic                    tbl_we,
  input  logic [TBL_AW-1:0]       tbl_addr,
  input  logic [SAMPLE_WIDTH-1:0] tbl_data,
  preamble_tx_if.slave            src,
  output logic                    busy,
  output logic                    done,
  output logic                    underrun
);

  state_e                  state_q;
  logic [TBL_AW-1:0]       seg_len_q, idx_q, idx_adv, rd_base, rd_addr;
  logic [3:0]              num_reps_q, rep_q, rep_last;
  logic [7:0]              gap_len_q, gap_cnt_q;
  logic [SAMPLE_WIDTH-1:0] sample_q, tbl_rdata;
  logic                    done_q, underrun_q;
  logic                    abort, stb, seg_end, rep_end;

  preamble_tbl #(
    .AW(TBL_AW),
    .DW(SAMPLE_WIDTH)
  ) u_tbl (
    .clk  (clk),
    .we   (tbl_we),
    .waddr(tbl_addr),
    .wdata(tbl_data),
    .raddr(rd_addr),
    .rdata(tbl_rdata)
  );

  // The read address always points one entry ahead of the sample that will be on the
  // output after this edge, so back-to-back strobes never see a bubble.
  always_comb begin
    abort    = (state_q != StIdle) && !duc_in_enable;
    stb      = duc_in_strobe && duc_in_enable;
    seg_end  = (idx_q == seg_len_q);
    rep_last = (num_reps_q == 4'd0) ? 4'd0 : num_reps_q - 4'd1;
    rep_end  = (rep_q == rep_last);
    idx_adv  = seg_end ? '0 : idx_q + TBL_AW'(1);
    rd_base  = (state_q == StPreamble && stb) ? idx_adv : idx_q;
    rd_addr  = '0;
    if (state_q == StPrefetch || state_q == StPreamble) begin
      rd_addr = (rd_base == seg_len_q) ? '0 : rd_base + TBL_AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sample_q   <= '0;
      seg_len_q  <= '0;
      num_reps_q <= '0;
      gap_len_q  <= '0;
      idx_q      <= '0;
      rep_q      <= '0;
      gap_cnt_q  <= '0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      if (abort) begin
        state_q   <= StIdle;
        sample_q  <= '0;
        idx_q     <= '0;
        rep_q     <= '0;
        gap_cnt_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            sample_q <= '0;
            if (start && duc_in_enable) begin
              seg_len_q  <= seg_len;
              num_reps_q <= num_reps;
              gap_len_q  <= gap_len;
              idx_q      <= '0;
              rep_q      <= '0;
              gap_cnt_q  <= '0;
              state_q    <= StPrefetch;
            end
          end
          StPrefetch: begin
            sample_q <= tbl_rdata;
            state_q  <= StPreamble;
          end
          StPreamble: begin
            if (stb) begin
              if (seg_end && rep_end) begin
                // Peek at the stream head; it is only consumed by a strobe in StPayload.
                sample_q <= src.src_valid ? src.src_data : '0;
                idx_q    <= '0;
                rep_q    <= '0;
                state_q  <= StPayload;
              end else begin
                sample_q <= tbl_rdata;
                idx_q    <= idx_adv;
                if (seg_end) begin
                  rep_q <= rep_q + 4'd1;
                end
              end
            end
          end
          StPayload: begin
            if (stb) begin
              if (src.src_valid) begin
                if (src.src_last) begin
                  sample_q  <= '0;
                  gap_cnt_q <= '0;
                  if (gap_len_q == 8'd0) begin
                    state_q <= StIdle;
                    done_q  <= 1'b1;
                  end else begin
                    state_q <= StGap;
                  end
                end else begin
                  sample_q <= src.src_data;
                end
              end else begin
                sample_q   <= '0;
                underrun_q <= 1'b1;
              end
            end
          end
          StGap: begin
            sample_q <= '0;
            if (stb) begin
              if (gap_cnt_q == gap_len_q - 8'd1) begin
                gap_cnt_q <= '0;
                state_q   <= StIdle;
                done_q    <= 1'b1;
              end else begin
                gap_cnt_q <= gap_cnt_q + 8'd1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign src.src_ready  = (state_q == StPayload) && stb;
  assign duc_in_sample  = sample_q;
  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign underrun       = underrun_q;

endmodule
